fetch_unit_mo: RTL

- Parametrised successor to the single-outstanding fetch stage.
- Owns the fetch PC and can keep up to MAX_OUTSTANDING in-order instruction-memory requests in flight.
- Buffers returned instructions, each tagged with its PC, in an instruction buffer (ibuf) with a valid/ready handshake to decode.
- On a branch/exception redirect it flushes the ibuf and drops stale responses.

---
 rtl/fetch_unit_mo.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/fetch_unit_mo.sv
// Fetch stage keeping up to MAX_OUTSTANDING in-order imem requests in flight and a PC-tagged ibuf.
// Define FETCH_PERF_CNT_EN to add the perf_fetched / perf_dropped counter ports.
module fetch_unit_mo #(
  parameter int unsigned     XLEN            = 32,
  parameter int unsigned     MAX_OUTSTANDING = 2,
  parameter int unsigned     IBUF_DEPTH      = 4,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  output logic            imem_resp_ready,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_dropped
`endif
);

  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CNT_W = $clog2(IBUF_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;
  localparam int unsigned PTR_W = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(IBUF_DEPTH - 1);

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic [OUT_W-1:0] discard_q, discard_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

  logic [XLEN-1:0]  data_mem [IBUF_DEPTH];
  logic [XLEN-1:0]  pc_mem   [IBUF_DEPTH];

  logic [XLEN-1:0]  redirect_pc_aligned;
  logic [OCC_W-1:0] occupancy;
  logic             req_fire;
  logic             resp_fire;
  logic             drop_resp;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign redirect_pc_aligned = redirect_pc & ~XLEN'(3);

  // Slots are reserved for every in-flight request, so a response can always be accepted.
  assign occupancy       = {1'b0, count_q} + OCC_W'(outstanding_q);
  assign imem_req_valid  = reset_n & ~redirect_valid
                         & (outstanding_q < OUT_W'(MAX_OUTSTANDING))
                         & (occupancy < OCC_W'(IBUF_DEPTH));
  assign imem_req_addr   = fetch_pc_q;
  assign imem_resp_ready = 1'b1;

  assign req_fire  = imem_req_valid & imem_req_ready;
  assign resp_fire = imem_resp_valid;
  assign drop_resp = resp_fire & (redirect_valid | (discard_q != '0));
  assign push      = resp_fire & ~drop_resp;
  assign pop       = inst_valid & inst_ready & ~redirect_valid;

  assign inst_valid = (count_q != '0);
  assign inst_data  = data_mem[rd_ptr_q];
  assign inst_pc    = pc_mem[rd_ptr_q];

  always_comb begin
    // NOTE: every next-state value starts from its register so no path leaves it unassigned (no latch).
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q + OUT_W'(req_fire) - OUT_W'(resp_fire);
    discard_d     = discard_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;

    if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old path.
      fetch_pc_d = redirect_pc_aligned;
      resp_pc_d  = redirect_pc_aligned;
      discard_d  = outstanding_q - OUT_W'(resp_fire);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (resp_fire && discard_q != '0) discard_d = discard_q - OUT_W'(1);
      if (push) begin
        resp_pc_d = resp_pc_q + XLEN'(4);
        wr_ptr_d  = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // NOTE: ibuf storage is not reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= imem_resp_data;
      pc_mem[wr_ptr_q]   <= resp_pc_q;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_dropped_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_q + 32'(push);
      perf_dropped_q <= perf_dropped_q + 32'(drop_resp)
                      + (redirect_valid ? 32'(count_q) : 32'd0);
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_dropped = perf_dropped_q;
`endif

  a_outstanding_max: assert property (@(posedge clk) disable iff (!reset_n)
    outstanding_q <= OUT_W'(MAX_OUTSTANDING));
  a_discard_le_outstanding: assert property (@(posedge clk) disable iff (!reset_n)
    discard_q <= outstanding_q);
  a_resp_has_request: assert property (@(posedge clk) disable iff (!reset_n)
    resp_fire |-> (outstanding_q != '0));
  a_ibuf_credit: assert property (@(posedge clk) disable iff (!reset_n)
    occupancy <= OCC_W'(IBUF_DEPTH));

endmodule
